// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl -- WS2812B frame sequencer on the 50 MHz fabric clock.
// Pulls NUM_LEDS 24-bit colour words over a ready/valid handshake into a
// one-word holding register and shifts each word out MSB first with per-bit
// high/low timing. After the last word it holds the line low for the latch
// interval.
// Build option: define WS2812_RGB_SWAP_EN to accept {R,G,B} words and
// reorder them to the {G,R,B} wire order as they enter the holding register.
// Without it, words are sent exactly as supplied, so upstream provides GRB.
module ws2812_frame_ctrl #(
   parameter int NUM_LEDS     = 8,
   parameter int T1H          = 40,
   parameter int T1L          = 20,
   parameter int T0H          = 20,
   parameter int T0L          = 40,
   parameter int RESET_CYCLES = 3000
) (
   input  logic        Clock_50,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] pixel_data,
   input  logic        pixel_valid,
   output logic        pixel_ready,
   output logic        out,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   output logic [9:0]  led_index
);

   // The single cycle counter must cover the longest phase, which is normally the latch.
   localparam int MAX_HI  = (T1H > T0H) ? T1H : T0H;
   localparam int MAX_LO  = (T1L > T0L) ? T1L : T0L;
   localparam int MAX_BIT = (MAX_HI > MAX_LO) ? MAX_HI : MAX_LO;
   localparam int CNT_MAX = (MAX_BIT > RESET_CYCLES) ? MAX_BIT : RESET_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Counter load values: each phase counts down to zero, so load length-1.
   localparam logic [CNT_W-1:0] T1H_LD    = CNT_W'(T1H - 1);
   localparam logic [CNT_W-1:0] T1L_LD    = CNT_W'(T1L - 1);
   localparam logic [CNT_W-1:0] T0H_LD    = CNT_W'(T0H - 1);
   localparam logic [CNT_W-1:0] T0L_LD    = CNT_W'(T0L - 1);
   localparam logic [CNT_W-1:0] LATCH_LD  = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [9:0]       LAST_IDX  = 10'(NUM_LEDS - 1);
   localparam logic [9:0]       NUM_WORDS = 10'(NUM_LEDS);

   typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       bit_cnt_q;
   logic [23:0]      shift_q;
   logic [23:0]      hold_q;
   logic             hold_full_q;
   logic [9:0]       accepted_q;
   logic [9:0]       led_index_q;
   logic             out_q;
   logic             busy_q;
   logic             done_q;
   logic             underrun_q;

   logic [23:0]      hold_d;
   logic             xfer;

   function automatic logic [CNT_W-1:0] high_ld(input logic b);
      return b ? T1H_LD : T0H_LD;
   endfunction

   function automatic logic [CNT_W-1:0] low_ld(input logic b);
      return b ? T1L_LD : T0L_LD;
   endfunction

   // Colour ordering applied to a word as it enters the holding register.
   always_comb begin
`ifdef WS2812_RGB_SWAP_EN
      hold_d = {pixel_data[15:8], pixel_data[23:16], pixel_data[7:0]};
`else
      hold_d = pixel_data;
`endif
   end

   // Accept a word only while a frame runs, the buffer is free and the frame still needs words.
   assign pixel_ready = busy_q && !hold_full_q && (accepted_q < NUM_WORDS);
   assign xfer        = pixel_valid && pixel_ready;

   // Frame sequencer: buffer management, bit timing and all registered outputs.
   always_ff @(posedge Clock_50 or posedge reset) begin
      if (reset) begin
         // NOTE: the data registers are cleared as well, so a reset mid-frame
         // can never let a stale word leak into the next frame.
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         accepted_q  <= '0;
         led_index_q <= '0;
         out_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment to the
         // same register in this block overrides the defaults written above it.
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         if (xfer) begin
            accepted_q <= accepted_q + 10'd1;
            if (state_q != FETCH) begin
               hold_q      <= hold_d;
               hold_full_q <= 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               out_q <= 1'b0;
               if (start) begin
                  state_q     <= FETCH;
                  busy_q      <= 1'b1;
                  led_index_q <= '0;
                  accepted_q  <= '0;
               end
            end

            FETCH: begin
               out_q <= 1'b0;
               if (xfer) begin
                  // Word arrives while nothing is buffered: bypass the holding register.
                  shift_q   <= hold_d;
                  bit_cnt_q <= 5'd23;
                  cnt_q     <= high_ld(hold_d[23]);
                  out_q     <= 1'b1;
                  state_q   <= HIGH;
               end else if (hold_full_q) begin
                  shift_q     <= hold_q;
                  hold_full_q <= 1'b0;
                  bit_cnt_q   <= 5'd23;
                  cnt_q       <= high_ld(hold_q[23]);
                  out_q       <= 1'b1;
                  state_q     <= HIGH;
               end
            end

            HIGH: begin
               if (cnt_q == '0) begin
                  out_q   <= 1'b0;
                  cnt_q   <= low_ld(shift_q[23]);
                  state_q <= LOW;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end

            LOW: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else if (bit_cnt_q != 5'd0) begin
                  shift_q   <= {shift_q[22:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q - 5'd1;
                  cnt_q     <= high_ld(shift_q[22]);
                  out_q     <= 1'b1;
                  state_q   <= HIGH;
               end else if (led_index_q != LAST_IDX) begin
                  if (hold_full_q) begin
                     shift_q     <= hold_q;
                     hold_full_q <= 1'b0;
                     led_index_q <= led_index_q + 10'd1;
                     bit_cnt_q   <= 5'd23;
                     cnt_q       <= high_ld(hold_q[23]);
                     out_q       <= 1'b1;
                     state_q     <= HIGH;
                  end else begin
                     underrun_q <= 1'b1;
                     cnt_q      <= LATCH_LD;
                     state_q    <= LATCH;
                  end
               end else begin
                  cnt_q   <= LATCH_LD;
                  state_q <= LATCH;
               end
            end

            LATCH: begin
               out_q <= 1'b0;
               if (cnt_q == '0) begin
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  hold_full_q <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign out       = out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign underrun  = underrun_q;
   assign led_index = led_index_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// tb_ws2812_frame_ctrl -- two instances (1 LED and 3 LEDs) with a bit-level
// scoreboard: every accepted word pushes its expected 24 bits, and a line
// monitor pops one bit per high pulse and times the high and low phases.
module tb_ws2812_frame_ctrl;

   localparam int T1H          = 40;
   localparam int T1L          = 20;
   localparam int T0H          = 20;
   localparam int T0L          = 40;
   localparam int RESET_CYCLES = 3000;
   localparam int BIT_CYC      = 60;

   logic        Clock_50 = 1'b0;
   logic        reset    = 1'b0;
   logic        start_w [2];
   logic [23:0] data_w  [2];
   logic        valid_w [2];
   wire         ready_w [2];
   wire         out_w   [2];
   wire         busy_w  [2];
   wire         done_w  [2];
   wire         und_w   [2];
   wire  [9:0]  idx_w   [2];

   int checks = 0;
   int errors = 0;

   // Scoreboard and line-monitor state (index 0: 1-LED DUT, index 1: 3-LED DUT).
   bit          exp_q [$];
   int          cyc = 0;
   int          high_len [2];
   int          low_len [2];
   int          pend_low [2];
   bit          pend [2];
   int          bits_seen [2];
   int          first_rise [2];
   int          done_cycle [2];
   int          und_cycle [2];
   int          done_cnt [2];
   int          und_cnt [2];
   int          busy_cnt [2];
   logic [23:0] rx_word [2];

   // Driver bookkeeping.
   logic [23:0] words [3];
   logic        ready_after [3];
   int          hs_count;

   always #10 Clock_50 = ~Clock_50;

   ws2812_frame_ctrl #(.NUM_LEDS(1)) dut_one (
      .Clock_50(Clock_50), .reset(reset), .start(start_w[0]),
      .pixel_data(data_w[0]), .pixel_valid(valid_w[0]), .pixel_ready(ready_w[0]),
      .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]), .underrun(und_w[0]),
      .led_index(idx_w[0])
   );

   ws2812_frame_ctrl #(.NUM_LEDS(3)) dut_three (
      .Clock_50(Clock_50), .reset(reset), .start(start_w[1]),
      .pixel_data(data_w[1]), .pixel_valid(valid_w[1]), .pixel_ready(ready_w[1]),
      .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]), .underrun(und_w[1]),
      .led_index(idx_w[1])
   );

   // Line monitor: times each pulse, pops the scoreboard on every falling edge.
   always @(negedge Clock_50) begin : monitor
      bit exp_b;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            high_len[i] = 0; low_len[i] = 0; pend[i] = 0; bits_seen[i] = 0;
            exp_q.delete();
         end else begin
            if (busy_w[i] === 1'b1) busy_cnt[i]++;
            if (und_w[i] === 1'b1) begin und_cnt[i]++; und_cycle[i] = cyc; end
            if (done_w[i] === 1'b1) begin done_cnt[i]++; done_cycle[i] = cyc; end
            if (out_w[i] === 1'b1) begin
               if (high_len[i] == 0) begin
                  if (bits_seen[i] == 0) first_rise[i] = cyc;
                  checks++;
                  if (idx_w[i] !== 10'(bits_seen[i] / 24)) begin
                     errors++;
                     $display("FAIL led_index dut%0d bit %0d: got %0d want %0d", i, bits_seen[i], idx_w[i], bits_seen[i] / 24);
                  end
                  if (pend[i]) begin
                     checks++;
                     if (low_len[i] != pend_low[i]) begin
                        errors++;
                        $display("FAIL low_len dut%0d bit %0d: got %0d want %0d", i, bits_seen[i], low_len[i], pend_low[i]);
                     end
                  end
                  pend[i] = 0;
                  low_len[i] = 0;
               end
               high_len[i]++;
            end else begin
               if (high_len[i] > 0) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     exp_b = 1'b0;
                     $display("FAIL unexpected_bit dut%0d: got pulse of %0d want none", i, high_len[i]);
                  end else begin
                     exp_b = exp_q.pop_front();
                     if (high_len[i] != (exp_b ? T1H : T0H)) begin
                        errors++;
                        $display("FAIL high_len dut%0d bit %0d: got %0d want %0d", i, bits_seen[i], high_len[i], exp_b ? T1H : T0H);
                     end
                  end
                  rx_word[i]  = {rx_word[i][22:0], (high_len[i] > (T0H + T1H) / 2) ? 1'b1 : 1'b0};
                  pend_low[i] = exp_b ? T1L : T0L;
                  pend[i]     = 1;
                  low_len[i]  = 0;
                  high_len[i] = 0;
                  bits_seen[i]++;
               end
               if (done_w[i] === 1'b1) begin
                  checks++;
                  if (!pend[i] || low_len[i] != pend_low[i] + RESET_CYCLES) begin
                     errors++;
                     $display("FAIL latch_len dut%0d: got %0d want %0d", i, low_len[i], pend_low[i] + RESET_CYCLES);
                  end
                  pend[i] = 0;
               end
               if (pend[i]) low_len[i]++;
            end
         end
      end
   end

   task automatic clear_stats(input int id);
      high_len[id] = 0; low_len[id] = 0; pend[id] = 0; bits_seen[id] = 0;
      first_rise[id] = 0; done_cycle[id] = 0; und_cycle[id] = 0;
      done_cnt[id] = 0; und_cnt[id] = 0; busy_cnt[id] = 0; rx_word[id] = '0;
      exp_q.delete();
      hs_count = 0;
      for (int k = 0; k < 3; k++) ready_after[k] = 1'bx;
   endtask

   // Presents words[0..n-1] back to back; pushes expected bits on every handshake.
   task automatic present_words(input int id, input int n, input int budget);
      int          k = 0;
      int          guard = 0;
      bit          last_hs = 0;
      logic [23:0] w;
      while ((k < n || last_hs) && guard < budget && !reset) begin
         @(negedge Clock_50);
         #1;
         if (last_hs) begin
            ready_after[k-1] = ready_w[id];
            last_hs = 0;
         end
         if (k < n) begin
            valid_w[id] = 1'b1;
            data_w[id]  = words[k];
            if (ready_w[id] === 1'b1) begin
               w = words[k];
`ifdef WS2812_RGB_SWAP_EN
               w = {w[15:8], w[23:16], w[7:0]};
`endif
               for (int b = 23; b >= 0; b--) exp_q.push_back(w[b]);
               k++;
               last_hs = 1;
            end
         end else begin
            valid_w[id] = 1'b0;
         end
         guard++;
      end
      valid_w[id] = 1'b0;
      hs_count = k;
   endtask

   task automatic wait_done(input int id, input int budget, output bit seen);
      seen = 0;
      for (int c = 0; c < budget && !seen; c++) begin
         @(negedge Clock_50);
         #2;
         if (done_w[id] === 1'b1) seen = 1;
      end
   endtask

   task automatic run_frame(input int id, input int n, output bit seen);
      @(negedge Clock_50);
      #1;
      clear_stats(id);
      start_w[id] = 1'b1;
      fork
         present_words(id, n, 20000);
         begin @(negedge Clock_50); #1; start_w[id] = 1'b0; end
         wait_done(id, 20000, seen);
      join
      repeat (5) @(negedge Clock_50);
      #2;
   endtask

   task automatic test_reset;
      #1 reset = 1'b1;
      #4;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({out_w[i], busy_w[i], done_w[i], und_w[i], ready_w[i]} !== 5'b0 || idx_w[i] !== 10'd0) begin
            errors++;
            $display("FAIL reset_state dut%0d: got out=%b busy=%b done=%b und=%b rdy=%b idx=%0d want all 0",
                     i, out_w[i], busy_w[i], done_w[i], und_w[i], ready_w[i], idx_w[i]);
         end
      end
      repeat (3) @(negedge Clock_50);
      reset = 1'b0;
   endtask

   task automatic test_idle;
      for (int c = 0; c < 200; c++) begin
         @(negedge Clock_50);
         #2;
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out_w[i], busy_w[i], ready_w[i]} !== 3'b000) begin
               errors++;
               $display("FAIL idle dut%0d cycle %0d: got out=%b busy=%b rdy=%b want 0", i, c, out_w[i], busy_w[i], ready_w[i]);
            end
         end
      end
   endtask

   task automatic test_single_led;
      bit seen;
      words[0] = 24'hFF0000;
      run_frame(0, 1, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL single_done: got no done want done"); end
      checks++;
      if (done_cycle[0] - first_rise[0] != 24 * BIT_CYC + RESET_CYCLES) begin
         errors++;
         $display("FAIL single_frame_len: got %0d want %0d", done_cycle[0] - first_rise[0], 24 * BIT_CYC + RESET_CYCLES);
      end
      checks++;
      if (busy_cnt[0] != 1 + 24 * BIT_CYC + RESET_CYCLES) begin
         errors++;
         $display("FAIL single_busy_len: got %0d want %0d", busy_cnt[0], 1 + 24 * BIT_CYC + RESET_CYCLES);
      end
      checks++;
      if (done_cnt[0] != 1 || und_cnt[0] != 0) begin
         errors++;
         $display("FAIL single_pulses: got done=%0d und=%0d want done=1 und=0", done_cnt[0], und_cnt[0]);
      end
      checks++;
      if (bits_seen[0] != 24 || exp_q.size() != 0 || busy_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_end: got bits=%0d left=%0d busy=%b want 24 0 0", bits_seen[0], exp_q.size(), busy_w[0]);
      end
   endtask

   task automatic test_three_leds;
      bit seen;
      words[0] = 24'hAAAAAA;
      words[1] = 24'h000001;
      words[2] = 24'hFFFFFF;
      run_frame(1, 3, seen);
      checks++;
      if (!seen) begin errors++; $display("FAIL three_done: got no done want done"); end
      checks++;
      if (done_cycle[1] - first_rise[1] != 72 * BIT_CYC + RESET_CYCLES) begin
         errors++;
         $display("FAIL three_frame_len: got %0d want %0d", done_cycle[1] - first_rise[1], 72 * BIT_CYC + RESET_CYCLES);
      end
      checks++;
      if (busy_cnt[1] != 1 + 72 * BIT_CYC + RESET_CYCLES) begin
         errors++;
         $display("FAIL three_busy_len: got %0d want %0d", busy_cnt[1], 1 + 72 * BIT_CYC + RESET_CYCLES);
      end
      checks++;
      if (hs_count != 3 || ready_after[0] !== 1'b1 || ready_after[1] !== 1'b0 || ready_after[2] !== 1'b0) begin
         errors++;
         $display("FAIL three_ready: got hs=%0d rdy=%b%b%b want hs=3 rdy=100", hs_count, ready_after[0], ready_after[1], ready_after[2]);
      end
      checks++;
      if (done_cnt[1] != 1 || und_cnt[1] != 0 || bits_seen[1] != 72 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL three_end: got done=%0d und=%0d bits=%0d left=%0d want 1 0 72 0", done_cnt[1], und_cnt[1], bits_seen[1], exp_q.size());
      end
   endtask

   task automatic test_underrun;
      bit seen;
      words[0] = 24'h5A5A5A;
      run_frame(1, 1, seen);
      checks++;
      if (!seen || und_cnt[1] != 1 || done_cnt[1] != 1) begin
         errors++;
         $display("FAIL underrun_pulses: got done_seen=%0d und=%0d done=%0d want 1 1 1", seen, und_cnt[1], done_cnt[1]);
      end
      checks++;
      if (und_cycle[1] - first_rise[1] != 24 * BIT_CYC) begin
         errors++;
         $display("FAIL underrun_time: got %0d want %0d", und_cycle[1] - first_rise[1], 24 * BIT_CYC);
      end
      checks++;
      if (done_cycle[1] - und_cycle[1] != RESET_CYCLES) begin
         errors++;
         $display("FAIL underrun_latch: got %0d want %0d", done_cycle[1] - und_cycle[1], RESET_CYCLES);
      end
      checks++;
      if (busy_w[1] !== 1'b0 || bits_seen[1] != 24 || ready_after[0] !== 1'b1) begin
         errors++;
         $display("FAIL underrun_end: got busy=%b bits=%0d rdy=%b want 0 24 1", busy_w[1], bits_seen[1], ready_after[0]);
      end
   endtask

   task automatic test_reset_mid_frame;
      bit found = 0;
      bit seen;
      words[0] = 24'hAAAAAA;
      words[1] = 24'h000001;
      words[2] = 24'hFFFFFF;
      @(negedge Clock_50);
      #1;
      clear_stats(1);
      start_w[1] = 1'b1;
      fork
         present_words(1, 3, 20000);
         begin @(negedge Clock_50); #1; start_w[1] = 1'b0; end
         begin
            for (int c = 0; c < 5000 && !found; c++) begin
               @(negedge Clock_50);
               #2;
               if (idx_w[1] === 10'd1 && out_w[1] === 1'b1) found = 1;
            end
            checks++;
            if (!found) begin errors++; $display("FAIL mid_reach_led1: got no high phase want LED 1 high"); end
            #3 reset = 1'b1;
            #1;
            checks++;
            if ({out_w[1], busy_w[1], done_w[1], und_w[1], ready_w[1]} !== 5'b0 || idx_w[1] !== 10'd0) begin
               errors++;
               $display("FAIL mid_reset_state: got out=%b busy=%b done=%b und=%b rdy=%b idx=%0d want all 0",
                        out_w[1], busy_w[1], done_w[1], und_w[1], ready_w[1], idx_w[1]);
            end
         end
      join
      repeat (2) @(negedge Clock_50);
      reset = 1'b0;
      run_frame(1, 3, seen);
      checks++;
      if (!seen || bits_seen[1] != 72 || done_cycle[1] - first_rise[1] != 72 * BIT_CYC + RESET_CYCLES) begin
         errors++;
         $display("FAIL mid_restart: got done_seen=%0d bits=%0d len=%0d want 1 72 %0d",
                  seen, bits_seen[1], done_cycle[1] - first_rise[1], 72 * BIT_CYC + RESET_CYCLES);
      end
   endtask

   task automatic test_rgb_swap;
      bit          seen;
      logic [23:0] want;
`ifdef WS2812_RGB_SWAP_EN
      want = 24'h341256;
`else
      want = 24'h123456;
`endif
      words[0] = 24'h123456;
      run_frame(0, 1, seen);
      checks++;
      if (!seen || rx_word[0] !== want) begin
         errors++;
         $display("FAIL swap_word: got %06h (done_seen=%0d) want %06h", rx_word[0], seen, want);
      end
   endtask

   // Hard stop in case a wait is ever left unbounded by a broken DUT.
   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         start_w[i] = 1'b0;
         valid_w[i] = 1'b0;
         data_w[i]  = '0;
      end
      test_reset;
      test_idle;
      test_single_led;
      test_three_leds;
      test_underrun;
      test_reset_mid_frame;
      test_rgb_swap;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_ctrl.md
Name: ws2812_frame_ctrl

Overview:
- Frame-level sequencer for a WS2812B LED chain on the 50 MHz fabric clock.
- Pulls one 24-bit colour word per LED from an upstream pixel source over a ready/valid handshake, double-buffers it and generates the timed serial line.
- Sequences NUM_LEDS words per frame, then holds the line low for the latch/reset interval.
- Drives the LED data pin directly; the per-bit high/low timing matches the team's existing single-bit sender.

Parameters:
- NUM_LEDS, 8: LEDs per frame; range 1..1023.
- T1H, 40: high cycles for a '1' bit (0.8 us).
- T1L, 20: low cycles for a '1' bit.
- T0H, 20: high cycles for a '0' bit.
- T0L, 40: low cycles for a '0' bit.
- RESET_CYCLES, 3000: low cycles for the end-of-frame latch (60 us).

Ports:
- Clock_50, in, 1: 50 MHz clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: frame request; sampled only in IDLE.
- pixel_data, in, 24: colour word, sent MSB first.
- pixel_valid, in, 1: pixel_data is valid.
- pixel_ready, out, 1: holding register can accept a word.
- out, out, 1: serial line to the LED chain.
- busy, out, 1: a frame is in progress.
- done, out, 1: one-cycle pulse at the end of the latch interval.
- underrun, out, 1: one-cycle pulse when a frame is aborted for missing data.
- led_index, out, 10: index of the LED whose word is being shifted.

Behaviour:
- Reset (asynchronous): out=0, busy=0, done=0, underrun=0, pixel_ready=0, led_index=0, holding register empty, state IDLE. Reset mid-frame truncates the line immediately; no latch interval is generated.

Storage:
- 24-bit shift register plus one 24-bit holding register.
- A word transfers when pixel_valid and pixel_ready are both 1 on a clock edge.
- pixel_ready=1 iff busy, the holding register is empty, and fewer than NUM_LEDS words have been accepted this frame.
- pixel_data is not sampled when pixel_ready=0.

FSM states: IDLE, FETCH, HIGH, LOW, LATCH.
- IDLE: out=0. If start=1, go to FETCH, set busy=1, clear led_index and the accepted-word count. start is ignored in every other state.
- FETCH (LED 0 only): out=0. Waits indefinitely. When the holding register is full, move it to the shift register (freeing the holding register) and go to HIGH with the bit counter at 23. If the handshake and the move occur in the same cycle, the word goes straight to the shift register.
- HIGH: out=1 for TxH cycles (T1H or T0H, selected by the current MSB), then go to LOW.
- LOW: out=0 for TxL cycles. On the last LOW cycle:
  - Bits remain: shift left, decrement the bit counter, go to HIGH.
  - Last bit, led_index < NUM_LEDS-1, holding register full: load the shift register, increment led_index, go to HIGH with no gap.
  - Last bit, led_index < NUM_LEDS-1, holding register empty: pulse underrun, go to LATCH.
  - Last bit, led_index = NUM_LEDS-1: go to LATCH.
- LATCH: out=0 for RESET_CYCLES cycles. Then pulse done for 1 cycle, clear busy, discard any buffered word, go to IDLE.
- done and underrun are never asserted in the same cycle. start is honoured in the cycle after done.

Timing:
- Bit period = TxH+TxL = 60 cycles (1.2 us) at the defaults.
- Frame length = 24*60*NUM_LEDS + RESET_CYCLES cycles.
- The first rising edge of out occurs the cycle after FETCH loads the shift register.
- The cycle counter must hold max(T1H, T1L, T0H, T0L, RESET_CYCLES); size it with $clog2.

Optional Feature:
- WS2812_RGB_SWAP_EN defined: pixel_data is interpreted as {R[23:16], G[15:8], B[7:0]} and reordered to {G, R, B} when the word enters the holding register.
- Undefined: the word is sent exactly as supplied. Upstream then provides GRB order.

Test Plan:
- Reset then idle, start=0 -> out=0, busy=0 and pixel_ready=0 indefinitely.
- NUM_LEDS=1, start, pixel_data=0xFF0000 valid -> eight bits of 40 high/20 low, then sixteen bits of 20 high/40 low (1440 cycles), then 3000 low cycles, then a single done pulse.
- NUM_LEDS=3, words 0xAAAAAA, 0x000001, 0xFFFFFF presented continuously -> pixel_ready drops after each fill, no gap between LEDs, led_index steps 0, 1, 2, total busy time 4320+3000 cycles.
- NUM_LEDS=3, pixel_valid dropped after the first word -> underrun pulse at the end of LED 0's 24th bit, 3000 low cycles, then done; busy clears.
- reset asserted during a HIGH phase of LED 1 -> out=0 in the same cycle without waiting for a clock, all outputs return to reset values, and the next start begins at led_index 0.
- With WS2812_RGB_SWAP_EN, pixel_data=0x123456 -> line carries bits of 0x341256. Without it -> line carries 0x123456.
